serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder for WIDTH-bit operands. Each cycle, one LSB-first bit pair passes through a single registered full-adder cell, and the carry is held in a flip-flop between cycles. This trades latency for area against the parallel ripple adder. The block sits downstream of the half-adder cell: two half adders form its full-adder slice, and it consumes their sum and carry outputs every cycle.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 1 to 64.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to begin an addition; sampled only in IDLE and DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while a bit-serial addition is in progress (RUN).
- done  output  1  single-cycle pulse when a result becomes valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  carry out of bit WIDTH-1; holds with sum.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE -> RUN on start: load a, b into the A/B shift registers, load carry with cin, clear the bit counter.
  - RUN: each edge performs one bit step (below). After the WIDTH-th step, go to DONE.
  - DONE -> RUN if start is high (back-to-back accept); otherwise DONE -> IDLE.
- Bit step:
  - s = A[0]^B[0]^carry; c = majority(A[0], B[0], carry).
  - Shift A and B right by one; shift s into the MSB of the internal sum shift register; carry <= c; counter++.
- On the final RUN edge, copy the completed shift register into sum and the final carry into cout.
- Arithmetic: {cout, sum} = a + b + cin, exact in WIDTH+1 bits. Overflow wraps into cout and is never flagged separately.
- Bit counter width is $clog2(WIDTH+1). The terminal count is WIDTH-1, checked before the increment.
- start while in RUN is ignored. Operands are not re-sampled and the in-flight addition is unaffected.
- a, b and cin are don't-care outside the accepting edge.
- Reset values:
  - state IDLE; busy 0; done 0; sum 0; cout 0.
  - carry, shift registers and counter all 0.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and sum/cout become 0 on that edge.

## Timing
- Start is accepted at the edge ending cycle k.
- busy = 1 in cycles k+1 through k+WIDTH.
- done = 1 and busy = 0 in cycle k+WIDTH+1. sum and cout are valid in that cycle and stay stable afterwards.
- Latency from start edge to done is WIDTH+1 cycles.
- Throughput is one result per WIDTH+1 cycles when start is held high continuously.
- busy and done are never high in the same cycle.
- done is registered; no output depends combinationally on any input.
- With WIDTH = 1: one RUN cycle, then DONE.

## Structure
- The shared package serial_adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE as a 2-bit enum);
  - the default WIDTH constant.
- Sub-module full_adder_cell:
  - combinational one-bit full adder built from two half-adder cells, with the carries ORed;
  - instantiated once; the carry flip-flop lives in the parent.
- The parent contains the FSM, the shift registers, the counter and the result registers.

## Test plan
- Basic add and reset values: after rst, check busy=0, done=0, sum=0x00, cout=0. Then a=0x7F, b=0x01, cin=0 with start for one cycle -> busy for 8 cycles; done in the 9th cycle; sum=0x80, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- start ignored in RUN: a start pulse with new operands 3 cycles into RUN -> original result is delivered at the original time, and only one done pulse occurs.
- Back-to-back: start held high with 0x01+0x01 and then 0x10+0x20 -> done pulses 9 cycles apart with sum=0x02, then sum=0x30. busy is low only in the DONE cycles.
- Reset mid-operation: rst for one cycle at RUN step 4 -> next cycle is IDLE with sum=0, cout=0, and no done pulse. A subsequent 0x03+0x04 gives 0x07.
- Parameter corners:
  - WIDTH=1: 1+1, cin=1 -> sum=1, cout=1, done 2 cycles after start.
  - WIDTH=16: 0xFFFF+0x0001 -> sum=0x0000, cout=1, done at cycle 17.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder: two half adders with their carries ORed.
module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic ab_s;
   logic ab_c;
   logic abc_c;

   half_adder_cell u_ha_ab (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (ab_s),
      .c_o (ab_c)
   );

   half_adder_cell u_ha_c (
      .a_i (ab_s),
      .b_i (c_i),
      .s_o (s_o),
      .c_o (abc_c)
   );

   assign c_o = ab_c | abc_c;

endmodule

// File: rtl/half_adder_cell.sv
// One-bit half adder.
module half_adder_cell (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one LSB-first bit pair per cycle through a single full-adder cell,
// with the carry held in a flip-flop between cycles.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  sr_q, sr_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              fa_s;
   logic              fa_c;

   full_adder_cell u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // Next-state: accept in IDLE/DONE, one bit step per RUN edge, publish result on last step.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sr_d    = sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StRun;
               a_d     = a_i;
               b_d     = b_i;
               carry_d = cin_i;
               cnt_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            sr_d           = sr_q >> 1;
            sr_d[WIDTH-1]  = fa_s;
            carry_d        = fa_c;
            cnt_d          = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               sum_d   = sr_d;
               cout_d  = fa_c;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset; reset mid-RUN aborts and clears the result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sr_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sr_q    <= sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == StRun);
   assign done_o = (state_q == StDone);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH = 8, 1 and 16.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        st [3];
   logic [63:0] av [3];
   logic [63:0] bv [3];
   logic        cv [3];

   logic        busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        busy1, done1, cout1;
   logic [0:0]  sum1;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(st[0]), .a_i(av[0][7:0]), .b_i(bv[0][7:0]),
      .cin_i(cv[0]), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(st[1]), .a_i(av[1][0:0]), .b_i(bv[1][0:0]),
      .cin_i(cv[1]), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(st[2]), .a_i(av[2][15:0]), .b_i(bv[2][15:0]),
      .cin_i(cv[2]), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wid(input int sel);
      case (sel)
         0:       return 8;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return done8;
         1:       return done1;
         default: return done16;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return busy8;
         1:       return busy1;
         default: return busy16;
      endcase
   endfunction

   function automatic logic get_cout(input int sel);
      case (sel)
         0:       return cout8;
         1:       return cout1;
         default: return cout16;
      endcase
   endfunction

   function automatic logic [63:0] get_sum(input int sel);
      case (sel)
         0:       return 64'(sum8);
         1:       return 64'(sum1);
         default: return 64'(sum16);
      endcase
   endfunction

   // busy and done must never be high together
   always @(negedge clk) begin
      check_eq("busy_done_excl",
               64'({busy8 & done8, busy1 & done1, busy16 & done16}), 64'd0);
   end

   // One addition: reference is plain (a + b + cin) in wide arithmetic. inj > 0 pulses a
   // start with fresh operands that many cycles into RUN, which must be ignored.
   task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input int inj, input string tag);
      int          w;
      int          lat;
      int          nbusy;
      logic [64:0] mask;
      logic [64:0] full;
      w     = wid(sel);
      mask  = (65'd1 << w) - 65'd1;
      full  = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(c);
      st[sel] = 1'b1;
      av[sel] = a;
      bv[sel] = b;
      cv[sel] = c;
      @(negedge clk);
      st[sel] = 1'b0;
      av[sel] = {$urandom, $urandom};
      bv[sel] = {$urandom, $urandom};
      cv[sel] = 1'($urandom_range(0, 1));
      lat   = 1;
      nbusy = 0;
      while (!get_done(sel) && lat < w + 10) begin
         if (get_busy(sel)) nbusy++;
         if (lat == inj) begin
            st[sel] = 1'b1;
            av[sel] = {$urandom, $urandom};
            bv[sel] = {$urandom, $urandom};
         end
         @(negedge clk);
         st[sel] = 1'b0;
         lat++;
      end
      check_eq({tag, "_done"}, 64'(get_done(sel)), 64'd1);
      check_eq({tag, "_latency"}, 64'(lat), 64'(w + 1));
      check_eq({tag, "_busy_cycles"}, 64'(nbusy), 64'(w));
      check_eq({tag, "_sum"}, get_sum(sel), full[63:0] & mask[63:0]);
      check_eq({tag, "_cout"}, 64'(get_cout(sel)), 64'(full[w]));
      @(negedge clk);
      check_eq({tag, "_single_pulse"}, 64'(get_done(sel)), 64'd0);
      check_eq({tag, "_sum_hold"}, get_sum(sel), full[63:0] & mask[63:0]);
   endtask

   initial begin
      int t;
      int first;
      int second;
      int idle_nd;
      int ndone;

      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         av[i] = '0;
         bv[i] = '0;
         cv[i] = 1'b0;
      end

      // Reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_busy", 64'(busy8), 64'd0);
      check_eq("rst_done", 64'(done8), 64'd0);
      check_eq("rst_sum", 64'(sum8), 64'd0);
      check_eq("rst_cout", 64'(cout8), 64'd0);
      check_eq("rst_w16_sum", 64'(sum16), 64'd0);

      // Directed W8 cases
      run_op(0, 64'h7F, 64'h01, 1'b0, 0, "basic");
      run_op(0, 64'hFF, 64'h01, 1'b0, 0, "ripple_ff");
      run_op(0, 64'hA5, 64'h5A, 1'b1, 0, "ripple_a5");
      run_op(0, 64'h12, 64'h34, 1'b0, 3, "ignore_run");
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check_eq("ignore_run_no_extra_done", 64'(ndone), 64'd0);

      // Reset at RUN step 4 aborts with no done and clears the result
      st[0] = 1'b1;
      av[0] = 64'h55;
      bv[0] = 64'h11;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_busy", 64'(busy8), 64'd0);
      check_eq("midrst_done", 64'(done8), 64'd0);
      check_eq("midrst_sum", 64'(sum8), 64'd0);
      check_eq("midrst_cout", 64'(cout8), 64'd0);
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check_eq("midrst_no_done", 64'(ndone), 64'd0);
      run_op(0, 64'h03, 64'h04, 1'b0, 0, "after_rst");

      // Back-to-back with start held high
      st[0] = 1'b1;
      av[0] = 64'h01;
      bv[0] = 64'h01;
      cv[0] = 1'b0;
      t       = 0;
      first   = -1;
      second  = -1;
      idle_nd = 0;
      while (second < 0 && t < 40) begin
         @(negedge clk);
         t++;
         if (done8) begin
            if (first < 0) begin
               first = t;
               check_eq("b2b_sum1", 64'(sum8), 64'h02);
               av[0] = 64'h10;
               bv[0] = 64'h20;
            end else begin
               second = t;
               check_eq("b2b_sum2", 64'(sum8), 64'h30);
               st[0] = 1'b0;
            end
         end else if (!busy8) begin
            idle_nd++;
         end
      end
      st[0] = 1'b0;
      check_eq("b2b_first_latency", 64'(first), 64'd9);
      check_eq("b2b_spacing", 64'(second - first), 64'd9);
      check_eq("b2b_busy_gap", 64'(idle_nd), 64'd0);
      @(negedge clk);

      // Randomized W8
      for (int i = 0; i < 20; i++) begin
         run_op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                (i % 4 == 0) ? 2 : 0, "rnd8");
      end

      // Parameter corners
      run_op(1, 64'h1, 64'h1, 1'b1, 0, "w1_corner");
      run_op(2, 64'hFFFF, 64'h0001, 1'b0, 0, "w16_corner");
      for (int i = 0; i < 6; i++) begin
         run_op(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                0, "rnd1");
         run_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                0, "rnd16");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
